// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring shift-and-subtract divider producing quotient and
// remainder for signed or unsigned operands, with RV32M-style handling of
// divide-by-zero and signed overflow.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start_i        request, sampled only while idle
//   signed_op_i    1 = two's-complement division, 0 = unsigned
//   dividend_i     dividend, sampled with start_i
//   divisor_i      divisor, sampled with start_i
//   busy_o         high from the cycle after acceptance until done_o falls
//   done_o         one-cycle pulse, results valid from this cycle onward
//   quotient_o     quotient, held until the next accepted start
//   remainder_o    remainder, held until the next accepted start
//   div_by_zero_o  divide-by-zero flag of the last operation
// -----------------------------------------------------------------------------
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             signed_op_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_by_zero_o
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state_q;
   logic [WIDTH:0]   rem_q;       // partial remainder, one extra bit for the borrow
   logic [WIDTH-1:0] dvd_q;       // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] dsr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             neg_quo_q;
   logic             neg_rem_q;
   logic             dbz_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             div_by_zero_q;

   // Operand magnitudes; the most negative value negates to itself, which is
   // exactly its magnitude when read as unsigned.
   logic             dividend_neg;
   logic             divisor_neg;
   logic [WIDTH-1:0] dividend_abs;
   logic [WIDTH-1:0] divisor_abs;
   logic             is_div_zero;
   logic             is_overflow;

   assign dividend_neg = signed_op_i & dividend_i[WIDTH-1];
   assign divisor_neg  = signed_op_i & divisor_i[WIDTH-1];
   assign dividend_abs = dividend_neg ? -dividend_i : dividend_i;
   assign divisor_abs  = divisor_neg  ? -divisor_i  : divisor_i;
   assign is_div_zero  = (divisor_i == '0);
   assign is_overflow  = signed_op_i && (dividend_i == MIN_NEG) && (divisor_i == ALL_ONES);

   // One restoring step: shift the next dividend bit into the remainder and
   // try subtracting the divisor; a set top bit of the trial means a borrow.
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] trial;
   logic             borrow;
   logic [WIDTH:0]   rem_d;
   logic [WIDTH-1:0] dvd_d;

   assign shifted = {rem_q, dvd_q[WIDTH-1]};
   assign trial   = shifted - {2'b00, dsr_q};
   assign borrow  = trial[WIDTH+1];
   assign rem_d   = borrow ? shifted[WIDTH:0] : trial[WIDTH:0];
   assign dvd_d   = {dvd_q[WIDTH-2:0], ~borrow};

   // NOTE: every register here is state, so it is written with non-blocking
   // assignments; blocking ones would let later statements see new values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rem_q         <= '0;
         dvd_q         <= '0;
         dsr_q         <= '0;
         cnt_q         <= '0;
         neg_quo_q     <= 1'b0;
         neg_rem_q     <= 1'b0;
         dbz_q         <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         div_by_zero_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  busy_q <= 1'b1;
                  // Special cases preload the final values and pass through
                  // FIX untouched, so they report two cycles after start.
                  if (is_div_zero) begin
                     dvd_q     <= ALL_ONES;
                     rem_q     <= {1'b0, dividend_i};
                     neg_quo_q <= 1'b0;
                     neg_rem_q <= 1'b0;
                     dbz_q     <= 1'b1;
                     state_q   <= FIX;
                  end else if (is_overflow) begin
                     dvd_q     <= MIN_NEG;
                     rem_q     <= '0;
                     neg_quo_q <= 1'b0;
                     neg_rem_q <= 1'b0;
                     dbz_q     <= 1'b0;
                     state_q   <= FIX;
                  end else begin
                     dvd_q     <= dividend_abs;
                     dsr_q     <= divisor_abs;
                     rem_q     <= '0;
                     cnt_q     <= CNT_W'(WIDTH);
                     neg_quo_q <= dividend_neg ^ divisor_neg;
                     neg_rem_q <= dividend_neg;
                     dbz_q     <= 1'b0;
                     state_q   <= CALC;
                  end
               end
            end
            CALC: begin
               if (cnt_q == '0) begin
                  state_q <= FIX;
               end else begin
                  rem_q <= rem_d;
                  dvd_q <= dvd_d;
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            FIX: begin
               quotient_q    <= neg_quo_q ? -dvd_q : dvd_q;
               remainder_q   <= neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
               div_by_zero_q <= dbz_q;
               done_q        <= 1'b1;
               state_q       <= DONE;
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign quotient_o    = quotient_q;
   assign remainder_o   = remainder_q;
   assign div_by_zero_o = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed bench for seq_divider. The driver pushes the expected result of
// each accepted request into a scoreboard queue; an independent monitor pops
// and compares whenever done_o is seen, including the edge count from the
// accepting edge to the done cycle.
// -----------------------------------------------------------------------------
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic        signed_op_i = 1'b0;
   logic [31:0] dividend_i = '0;
   logic [31:0] divisor_i = '0;
   logic        busy_o;
   logic        done_o;
   logic [31:0] quotient_o;
   logic [31:0] remainder_o;
   logic        div_by_zero_o;

   seq_divider #(.WIDTH(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .signed_op_i   (signed_op_i),
      .dividend_i    (dividend_i),
      .divisor_i     (divisor_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .quotient_o    (quotient_o),
      .remainder_o   (remainder_o),
      .div_by_zero_o (div_by_zero_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   localparam int LAT_NORM = 34;   // edges from accepting edge to done cycle
   localparam int LAT_SPEC = 1;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every done pulse against the oldest expectation.
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_done = 1'b0;
      end else begin
         if (done_o) begin
            check("done_single_pulse", {31'b0, prev_done}, 32'd0);
            check("busy_with_done", {31'b0, busy_o}, 32'd1);
            if (sb.size() == 0) begin
               check("spurious_done", {31'b0, done_o}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("quotient", quotient_o, e.q);
               check("remainder", remainder_o, e.r);
               check("div_by_zero", {31'b0, div_by_zero_o}, {31'b0, e.z});
               check("latency", cyc - e.acc, e.lat);
            end
         end
         prev_done = done_o;
      end
   end

   // Called at a negedge: waits for idle, issues one request, records expectation.
   task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input logic z,
                        input int lat);
      int guard = 0;
      while ((busy_o || done_o) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check("idle_timeout", {31'b0, busy_o}, 32'd0);
      signed_op_i = s;
      dividend_i  = a;
      divisor_i   = b;
      start_i     = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check("busy_after_start", {31'b0, busy_o}, 32'd1);
      sb.push_back('{q: q, r: r, z: z, lat: lat, acc: cyc});
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!done_o) begin
         check("done_timeout", {31'b0, done_o}, 32'd1);
         if (sb.size() != 0) void'(sb.pop_front());
      end
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", {31'b0, busy_o}, 32'd0);
      check("rst_done", {31'b0, done_o}, 32'd0);
      check("rst_quotient", quotient_o, 32'd0);
      check("rst_remainder", remainder_o, 32'd0);
      check("rst_dbz", {31'b0, div_by_zero_o}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Normal-path directed vectors
      do_op(1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, LAT_NORM); wait_done();
      do_op(1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, LAT_NORM); wait_done();
      do_op(1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, LAT_NORM); wait_done();
      do_op(1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, LAT_NORM); wait_done();
      do_op(1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, LAT_NORM); wait_done();
      do_op(1'b0, 32'd5,          32'hFFFF_FFFF,  32'd0,          32'd5,          1'b0, LAT_NORM); wait_done();
      do_op(1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, LAT_NORM); wait_done();

      // Special cases
      do_op(1'b0, 32'd15,         32'd0,          32'hFFFF_FFFF,  32'd15,         1'b1, LAT_SPEC); wait_done();
      do_op(1'b1, 32'd15,         32'd0,          32'hFFFF_FFFF,  32'd15,         1'b1, LAT_SPEC); wait_done();
      do_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, LAT_SPEC); wait_done();

      // start while busy is ignored and operands may change mid-operation
      do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT_NORM);
      repeat (10) @(negedge clk);
      dividend_i = 32'd9;
      divisor_i  = 32'd3;
      start_i    = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      wait_done();
      // start held through the done cycle is only taken once done has fallen
      start_i = 1'b1;
      @(negedge clk);
      check("done_cycle_start_ignored", {31'b0, busy_o}, 32'd0);
      @(negedge clk);
      start_i = 1'b0;
      check("busy_after_late_start", {31'b0, busy_o}, 32'd1);
      sb.push_back('{q: 32'd3, r: 32'd0, z: 1'b0, lat: LAT_NORM, acc: cyc});
      wait_done();

      // Asynchronous reset mid-calculation drops the operation
      @(negedge clk);
      signed_op_i = 1'b0;
      dividend_i  = 32'd100;
      divisor_i   = 32'd7;
      start_i     = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'b0, busy_o}, 32'd0);
      check("midrst_done", {31'b0, done_o}, 32'd0);
      check("midrst_quotient", quotient_o, 32'd0);
      check("midrst_remainder", remainder_o, 32'd0);
      check("midrst_dbz", {31'b0, div_by_zero_o}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      do_op(1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, LAT_NORM); wait_done();

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
